display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Downstream consumer of the two-digit counter/display stage.
- Takes its two 7-segment patterns (BCD_digit_1, BCD_digit_2) and time-multiplexes them onto one shared segment bus with per-digit anode enables.
- Latches a coherent digit pair per frame and inserts blanking gaps between digits to suppress ghosting.
- Sits between the counter/decoder logic and the board's 7-segment pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit per slot; must be >= 1.
- BLANK_CYCLES, 4, clock cycles of full blanking before each digit slot; 0 removes the blank states.
- SEG_ACTIVE_LOW, 1, 1 means segments are lit by 0 and the blank pattern is 7'b111_1111; 0 means lit by 1 and blank is 7'b000_0000.
- AN_ACTIVE_LOW, 1, 1 means anodes are enabled by 0 and "off" is 2'b11; 0 means enabled by 1 and "off" is 2'b00.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset on the next rising clk edge).
- BCD_digit_1  input  7  segment pattern for digit 1 (shown on an_out[0]); passed through unmodified.
- BCD_digit_2  input  7  segment pattern for digit 2 (shown on an_out[1]).
- seg_out  output  7  shared segment bus.
- an_out  output  2  anode enables; at most one is active in any cycle.
- frame_sync  output  1  one-cycle pulse marking the first lit cycle of each frame.

Behaviour:
- Moore FSM with states S_BLANK1, S_DIG1, S_BLANK2, S_DIG2; fixed cyclic order S_BLANK1 -> S_DIG1 -> S_BLANK2 -> S_DIG2 -> S_BLANK1.
- Slot timer:
  - Loaded with BLANK_CYCLES-1 on entry to a blank state and REFRESH_DIV-1 on entry to a digit state.
  - The state advances on the edge where the timer equals 0.
  - If BLANK_CYCLES=0, blank states are never entered: S_DIG1 <-> S_DIG2.
- Frame period = 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Shadow registers sh1/sh2 load BCD_digit_1/BCD_digit_2 on the edge entering S_DIG1, and only then.
  - Input changes mid-frame are not visible until the next frame.
  - Inputs need no synchronization; they come from the same clock domain.
- Outputs decode from registered state only (no combinational path from inputs):
  - S_BLANKx: seg_out = blank pattern, an_out = all off.
  - S_DIG1: seg_out = sh1, an_out[0] active.
  - S_DIG2: seg_out = sh2, an_out[1] active.
- frame_sync is registered: high only in the first cycle of S_DIG1.
- Reset (reset=0 at a rising edge):
  - Next state is S_BLANK1 with timer loaded; if BLANK_CYCLES=0, S_DIG1 instead, with shadows loaded from the inputs on that same edge.
  - sh1/sh2 = blank pattern, seg_out = blank, an_out = off, frame_sync = 0.
  - Reset dominates every other event, including reset asserted mid-slot; the scan restarts from the frame start.
- Timer width = $clog2(max(REFRESH_DIV, BLANK_CYCLES, 2)) bits; no wrap-around is reachable.

Optional Feature:
- Macro DISPLAY_SCAN_MUX_DIMMING_EN.
- Defined:
  - Adds input port duty [3:0] and a free-running 4-bit pwm counter, reset to 0, incrementing every cycle.
  - In digit states, seg_out = shadow pattern when pwm_cnt < duty, otherwise blank; an_out is unaffected.
  - duty=0 gives a permanently blank display; duty=15 gives 15/16 brightness.
  - duty is sampled every cycle.
- Undefined: no duty port; segments are fully lit in digit states.

Decomposition:
- Package display_pkg holds:
  - State enum scan_state_t.
  - Constants SEG_BLANK_AL = 7'b111_1111 and AN_OFF_AL = 2'b11.
  - A seg_t typedef, logic [6:0], shared with the counter/decoder stage.
- One sub-module, display_slot_timer: loadable down-counter with a load value input, load strobe and zero flag.
- The FSM, shadow registers and output decode stay in display_scan_mux.

Test Plan (REFRESH_DIV=3, BLANK_CYCLES=1, active-low defaults, period 8 cycles):
1. Hold reset=0 for 2 edges -> seg_out=7'b111_1111, an_out=2'b11, frame_sync=0 throughout.
2. Release reset with BCD_digit_1=7'b010_0000 and BCD_digit_2=7'b001_0010. Expected, counting cycles after release:
   - Cycle 1: blank.
   - Cycles 2-4: an_out=2'b10, seg_out=7'b010_0000; frame_sync=1 in cycle 2 only.
   - Cycle 5: blank.
   - Cycles 6-8: an_out=2'b01, seg_out=7'b001_0010.
   - The frame then repeats, giving exactly one frame_sync per 8 cycles.
3. Change BCD_digit_2 to 7'b100_1111 during S_DIG1 -> the current S_DIG2 still shows 7'b001_0010; the next frame shows 7'b100_1111.
4. Drive reset=0 for one edge in the second cycle of S_DIG2 -> outputs blank on the next cycle; the sequence restarts at step 2 timing.
5. Rebuild with BLANK_CYCLES=0 -> an_out alternates 2'b10 x3 and 2'b01 x3, never 2'b11 after reset; period 6.
6. With DISPLAY_SCAN_MUX_DIMMING_EN defined:
   - duty=0: seg_out=7'b111_1111 in every cycle while an_out still scans.
   - duty=8: segments lit for exactly 8 of each 16 cycles (checked with a long REFRESH_DIV=32).

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit 7-segment display path.
package display_pkg;

  typedef enum logic [1:0] {S_BLANK1, S_DIG1, S_BLANK2, S_DIG2} scan_state_t;

  typedef logic [6:0] seg_t;

  localparam seg_t        SEG_BLANK_AL = 7'b111_1111;
  localparam logic [1:0]  AN_OFF_AL    = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/display_slot_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module display_slot_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load)          cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/display_scan_mux.sv
// Two-digit 7-segment scan multiplexer with per-frame shadowing and blanking gaps.
// Optional PWM dimming via DISPLAY_SCAN_MUX_DIMMING_EN (adds the duty port).
module display_scan_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
  input  logic [3:0] duty,
`endif
  input  logic [6:0] BCD_digit_1,
  input  logic [6:0] BCD_digit_2,
  output logic [6:0] seg_out,
  output logic [1:0] an_out,
  output logic       frame_sync
);

  localparam int   TW        = $clog2(max3(REFRESH_DIV, BLANK_CYCLES, 2));
  localparam bit   HAS_BLANK = (BLANK_CYCLES > 0);
  localparam seg_t SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK_AL : 7'b000_0000;
  localparam logic [TW-1:0] DIG_LOAD = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLK_LOAD = TW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

  scan_state_t   state, state_nx;
  seg_t          sh1, sh2;
  logic          zero, load, enter_dig1, lit;
  logic [TW-1:0] load_val;
  logic [1:0]    an_en;

  display_slot_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_comb begin
    state_nx = state;
    if (!reset) begin
      state_nx = HAS_BLANK ? S_BLANK1 : S_DIG1;
    end else if (zero) begin
      case (state)
        S_BLANK1: state_nx = S_DIG1;
        S_DIG1:   state_nx = HAS_BLANK ? S_BLANK2 : S_DIG2;
        S_BLANK2: state_nx = S_DIG2;
        S_DIG2:   state_nx = HAS_BLANK ? S_BLANK1 : S_DIG1;
        default:  state_nx = S_BLANK1;
      endcase
    end
    load       = !reset || zero;
    load_val   = (state_nx == S_DIG1 || state_nx == S_DIG2) ? DIG_LOAD : BLK_LOAD;
    enter_dig1 = load && (state_nx == S_DIG1);
  end

  // Without blank slots, reset lands directly in S_DIG1, so shadows load from the inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= state_nx;
      frame_sync <= 1'b0;
      sh1        <= HAS_BLANK ? SEG_BLANK : BCD_digit_1;
      sh2        <= HAS_BLANK ? SEG_BLANK : BCD_digit_2;
    end else begin
      state      <= state_nx;
      frame_sync <= enter_dig1;
      if (enter_dig1) begin
        sh1 <= BCD_digit_1;
        sh2 <= BCD_digit_2;
      end
    end
  end

`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
  logic [3:0] pwm_cnt, duty_q;

  always_ff @(posedge clk) begin
    if (!reset) pwm_cnt <= 4'd0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
    duty_q <= duty;
  end

  assign lit = (pwm_cnt < duty_q);
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    seg_out = SEG_BLANK;
    an_en   = 2'b00;
    case (state)
      S_DIG1: begin
        seg_out = lit ? sh1 : SEG_BLANK;
        an_en   = 2'b01;
      end
      S_DIG2: begin
        seg_out = lit ? sh2 : SEG_BLANK;
        an_en   = 2'b10;
      end
      default: ;
    endcase
    an_out = (AN_ACTIVE_LOW != 0) ? ~an_en : an_en;
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: scan table, mid-frame reset, no-blank build, dimming.
module tb_display_scan_mux;

  localparam logic [6:0] P1  = 7'b010_0000;
  localparam logic [6:0] P2  = 7'b001_0010;
  localparam logic [6:0] P3  = 7'b100_1111;
  localparam logic [6:0] BLK = 7'b111_1111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [6:0] d1, d2;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       fs_a, fs_b;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
  logic [3:0] duty_full = 4'd15;
  logic [3:0] duty_c;
  logic       rst_c;
  logic [6:0] pat_c = 7'b000_0000;
  logic [6:0] seg_c;
  logic [1:0] an_c;
  logic       fs_c;
  logic [3:0] pwm_a = 4'd0, pwm_b = 4'd0;

  always @(posedge clk) begin
    pwm_a <= !rst_a ? 4'd0 : pwm_a + 4'd1;
    pwm_b <= !rst_b ? 4'd0 : pwm_b + 4'd1;
  end

  display_scan_mux #(.REFRESH_DIV(32), .BLANK_CYCLES(1)) u_dim (
    .clk(clk), .reset(rst_c), .duty(duty_c),
    .BCD_digit_1(pat_c), .BCD_digit_2(pat_c),
    .seg_out(seg_c), .an_out(an_c), .frame_sync(fs_c)
  );
`endif

  display_scan_mux #(.REFRESH_DIV(3), .BLANK_CYCLES(1)) u_dut (
    .clk(clk), .reset(rst_a),
`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
    .duty(duty_full),
`endif
    .BCD_digit_1(d1), .BCD_digit_2(d2),
    .seg_out(seg_a), .an_out(an_a), .frame_sync(fs_a)
  );

  display_scan_mux #(.REFRESH_DIV(3), .BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst_b),
`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
    .duty(duty_full),
`endif
    .BCD_digit_1(d1), .BCD_digit_2(d2),
    .seg_out(seg_b), .an_out(an_b), .frame_sync(fs_b)
  );

  typedef struct {
    logic       rst;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [6:0] seg;
    logic [1:0] an;
    logic       fs;
  } vec_t;

  vec_t tv[30];

  initial begin
    logic [6:0] es, ex_seg;
    logic [1:0] ex_an;
    int         lit_cnt, scan_cnt, wait_cnt;
    bit         found;

    // record: inputs applied before an edge, outputs expected after it
    tv[0]  = '{1'b0, P1, P2, BLK, 2'b11, 1'b0};
    tv[1]  = '{1'b0, P1, P2, BLK, 2'b11, 1'b0};
    tv[2]  = '{1'b1, P1, P2, P1,  2'b10, 1'b1};
    tv[3]  = '{1'b1, P1, P2, P1,  2'b10, 1'b0};
    tv[4]  = '{1'b1, P1, P2, P1,  2'b10, 1'b0};
    tv[5]  = '{1'b1, P1, P2, BLK, 2'b11, 1'b0};
    tv[6]  = '{1'b1, P1, P2, P2,  2'b01, 1'b0};
    tv[7]  = '{1'b1, P1, P2, P2,  2'b01, 1'b0};
    tv[8]  = '{1'b1, P1, P2, P2,  2'b01, 1'b0};
    tv[9]  = '{1'b1, P1, P2, BLK, 2'b11, 1'b0};
    tv[10] = '{1'b1, P1, P2, P1,  2'b10, 1'b1};
    tv[11] = '{1'b1, P1, P3, P1,  2'b10, 1'b0};
    tv[12] = '{1'b1, P1, P3, P1,  2'b10, 1'b0};
    tv[13] = '{1'b1, P1, P3, BLK, 2'b11, 1'b0};
    tv[14] = '{1'b1, P1, P3, P2,  2'b01, 1'b0};
    tv[15] = '{1'b1, P1, P3, P2,  2'b01, 1'b0};
    tv[16] = '{1'b1, P1, P3, P2,  2'b01, 1'b0};
    tv[17] = '{1'b1, P1, P3, BLK, 2'b11, 1'b0};
    tv[18] = '{1'b1, P1, P3, P1,  2'b10, 1'b1};
    tv[19] = '{1'b1, P1, P3, P1,  2'b10, 1'b0};
    tv[20] = '{1'b1, P1, P3, P1,  2'b10, 1'b0};
    tv[21] = '{1'b1, P1, P3, BLK, 2'b11, 1'b0};
    tv[22] = '{1'b1, P1, P3, P3,  2'b01, 1'b0};
    tv[23] = '{1'b1, P1, P3, P3,  2'b01, 1'b0};
    tv[24] = '{1'b0, P1, P3, BLK, 2'b11, 1'b0};
    tv[25] = '{1'b1, P1, P3, P1,  2'b10, 1'b1};
    tv[26] = '{1'b1, P1, P3, P1,  2'b10, 1'b0};
    tv[27] = '{1'b1, P1, P3, P1,  2'b10, 1'b0};
    tv[28] = '{1'b1, P1, P3, BLK, 2'b11, 1'b0};
    tv[29] = '{1'b1, P1, P3, P3,  2'b01, 1'b0};

    rst_a = 1'b0; rst_b = 1'b0; d1 = P1; d2 = P2;
`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
    rst_c = 1'b0; duty_c = 4'd0;
`endif

    for (int i = 0; i < 30; i++) begin
      rst_a = tv[i].rst; d1 = tv[i].d1; d2 = tv[i].d2;
      @(negedge clk);
      es = tv[i].seg;
`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
      if (tv[i].an != 2'b11 && pwm_a == 4'd15) es = BLK;
`endif
      chk($sformatf("scan_seg[%0d]", i), int'(seg_a), int'(es));
      chk($sformatf("scan_an[%0d]", i),  int'(an_a),  int'(tv[i].an));
      chk($sformatf("scan_fs[%0d]", i),  int'(fs_a),  int'(tv[i].fs));
    end

    // no-blank build: reset lands in S_DIG1 with shadows taken from the inputs
    d1 = P1; d2 = P3; rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      ex_an  = (k % 6 < 3) ? 2'b10 : 2'b01;
      ex_seg = (k % 6 < 3) ? P1 : P3;
`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
      if (pwm_b == 4'd15) ex_seg = BLK;
`endif
      chk($sformatf("nb_an[%0d]", k),  int'(an_b),  int'(ex_an));
      chk($sformatf("nb_seg[%0d]", k), int'(seg_b), int'(ex_seg));
      chk($sformatf("nb_fs[%0d]", k),  int'(fs_b),  (k != 0 && k % 6 == 0) ? 1 : 0);
      rst_b = 1'b1;
      @(negedge clk);
    end

`ifdef DISPLAY_SCAN_MUX_DIMMING_EN
    // duty=0: never lit, anodes still scan
    duty_c = 4'd0; rst_c = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_c = 1'b1;
    scan_cnt = 0;
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      chk($sformatf("dim0_seg[%0d]", k), int'(seg_c), int'(BLK));
      if (an_c != 2'b11) scan_cnt++;
    end
    chk("dim0_scan_active", (scan_cnt > 0) ? 1 : 0, 1);

    // duty=8: 16 of 32 digit-1 cycles lit
    duty_c = 4'd8; rst_c = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_c = 1'b1;
    found = 1'b0; wait_cnt = 0;
    while (!found && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
      if (fs_c) found = 1'b1;
    end
    chk("dim8_sync_seen", found ? 1 : 0, 1);
    lit_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      if (an_c == 2'b10 && seg_c != BLK) lit_cnt++;
      @(negedge clk);
    end
    chk("dim8_lit_cycles", lit_cnt, 16);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
